// File: rtl/sound_request_scheduler.sv
// -----------------------------------------------------------------------------
// sound_request_scheduler
//   Arbitrates one-cycle sound-effect request pulses from NUM_REQ game-logic
//   sources onto the single codec playback path. Requests are latched into a
//   pending vector and granted by fixed priority (index 0 highest). Every
//   playback is sequenced as PLAY (sound_input high) followed by GAP
//   (sound_input low), so the codec side always sees a clean rising/falling pair.
//
//   Optional feature macro: SOUND_SCHED_PREEMPT_EN
//     defined   - a pending request with a lower index than the one playing
//                 ends PLAY early (enters GAP, no done, pending bits kept)
//     undefined - PLAY always runs to completion
//
// Ports
//   clk                  in   system clock
//   rst_n                in   asynchronous active-low reset
//   req[NUM_REQ]         in   one-cycle request pulses, bit i = requester i
//   stop                 in   abort playback and clear all pending requests
//   mute                 in   level; silences output without affecting sequencing
//   sound_input          out  high while a sample plays
//   sound_sample_select  out  sample ROM select of the granted requester
//   sound_enable         out  registered ~mute
//   grant[NUM_REQ]       out  one-hot requester currently playing, 0 when none
//   busy                 out  1 in PLAY or GAP
//   done                 out  one-cycle pulse when PLAY ends normally
// -----------------------------------------------------------------------------
module sound_request_scheduler #(
  parameter int unsigned        NUM_REQ     = 4,
  parameter logic [NUM_REQ-1:0] SAMPLE_MAP  = 4'b1010,
  parameter int unsigned        PLAY_CYCLES = 25_000_000,
  parameter int unsigned        GAP_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               stop,
  input  logic               mute,
  output logic               sound_input,
  output logic               sound_sample_select,
  output logic               sound_enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(PLAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               sound_input_q, sound_input_d;
  logic               sample_sel_q, sample_sel_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NUM_REQ-1:0] pick_c;
  logic [NUM_REQ-1:0] pending_clr_c;
  logic               preempt_c;

  // Isolate the lowest set pending bit (highest priority requester).
  assign pick_c = pending_q & NUM_REQ'(~pending_q + NUM_REQ'(1));

`ifdef SOUND_SCHED_PREEMPT_EN
  // grant_q - 1 masks every index below the one playing; same-cycle req counts.
  assign preempt_c = |((pending_q | req) & NUM_REQ'(grant_q - NUM_REQ'(1)));
`else
  assign preempt_c = 1'b0;
`endif

  // Next-state, counter, pending and output computation.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    grant_d       = grant_q;
    sound_input_d = sound_input_q;
    sample_sel_d  = sample_sel_q;
    enable_d      = ~mute;
    done_d        = 1'b0;
    pending_clr_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!stop && (|pending_q)) begin
          state_d       = ST_PLAY;
          grant_d       = pick_c;
          pending_clr_c = pick_c;
          sound_input_d = 1'b1;
          sample_sel_d  = |(pick_c & SAMPLE_MAP);
          counter_d     = '0;
        end
      end

      ST_PLAY: begin
        if (stop || (counter_q == PLAY_LAST) || preempt_c) begin
          state_d       = ST_GAP;
          grant_d       = '0;
          sound_input_d = 1'b0;
          counter_d     = '0;
          // Only a normal completion reports done; abort and preempt stay silent.
          done_d        = !stop && (counter_q == PLAY_LAST);
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (counter_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end

      default: begin
        state_d       = ST_IDLE;
        counter_d     = '0;
        grant_d       = '0;
        sound_input_d = 1'b0;
      end
    endcase

    // A new request beats the grant clear; stop beats everything.
    pending_d = stop ? '0 : ((pending_q & ~pending_clr_c) | req);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      counter_q     <= '0;
      pending_q     <= '0;
      grant_q       <= '0;
      sound_input_q <= 1'b0;
      sample_sel_q  <= 1'b0;
      enable_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      sound_input_q <= sound_input_d;
      sample_sel_q  <= sample_sel_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign sound_input         = sound_input_q;
  assign sound_sample_select = sample_sel_q;
  assign sound_enable        = enable_q;
  assign grant               = grant_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
